// File: rtl/dsm_dec_pkg.sv
// -----------------------------------------------------------------------------
// dsm_dec_pkg
// Shared types and helpers for the loopback CIC decimator.
//   state_e    : controller states (IDLE, WARMUP, RUN)
//   calc_gw    : internal CIC register width, MASH_BW + ORDER*DEC_LOG2
//   map_sample : selects the MASH sample or maps the DSM bit to +1/-1
// -----------------------------------------------------------------------------
package dsm_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    function automatic int calc_gw(input int mash_bw, input int order, input int dec_log2);
        return mash_bw + order * dec_log2;
    endfunction

    function automatic longint map_sample(input logic sel, input longint mash_val,
                                          input logic dsm_bit);
        if (sel) begin
            return dsm_bit ? 64'sd1 : -64'sd1;
        end
        return mash_val;
    endfunction

endpackage

// File: rtl/dsm_dec_fifo.sv
// -----------------------------------------------------------------------------
// dsm_dec_fifo
// Synchronous output FIFO with a valid/ready read port.
//   clk, rst_n      : clock, async active-low reset
//   flush           : synchronous clear of all entries
//   wr_en, wr_data  : write request; accepted when not full, or when full
//                     and a read happens in the same cycle
//   full            : all DEPTH entries occupied
//   rd_valid/ready  : head entry available / consumer accepts it
//   rd_data         : head entry, forced to zero while empty
//   level           : current occupancy
// DEPTH must be a power of two >= 2 so the pointers wrap on their own.
// -----------------------------------------------------------------------------
module dsm_dec_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             wr, rd;

    assign full     = (level_q == LW'(DEPTH));
    assign rd_valid = (level_q != '0);
    assign rd       = rd_valid & rd_ready;
    assign wr       = wr_en & ~flush & (~full | rd);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr, rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// dsm_cic_decimator
// Loopback demodulator: CIC (sinc^N) decimation of the MASH or DSM stream
// back to WIDTH-bit signed samples, with a buffered valid/ready output.
//   aclk, rst_n     : clock, async active-low reset
//   enable          : run when high; low flushes everything back to IDLE
//   in_sel          : 0 = in_mash_data, 1 = in_dsm_bit (1 -> +1, 0 -> -1)
//   in_mash_data    : signed MASH sample
//   in_dsm_bit      : 1-bit DSM sample
//   in_valid        : input qualifier, always accepted while enabled
//   out_data/valid  : decimated sample / sample present
//   out_ready       : consumer accepts on out_valid & out_ready
//   drop_count      : saturating count of samples lost to a full buffer
//   fifo_level      : output buffer occupancy
// Build option DSM_DEC_FIFO_EN: defined -> FIFO_DEPTH-entry output FIFO;
// undefined -> single output register (depth 1).
//
// state  | meaning
// IDLE   | enable low or just raised; datapath and buffer cleared
// WARMUP | first CIC_ORDER decimated samples discarded (combs filling)
// RUN    | decimated samples written to the output buffer
// -----------------------------------------------------------------------------
module dsm_cic_decimator
    import dsm_dec_pkg::*;
#(
    parameter int MASH_BW    = 3,
    parameter int WIDTH      = 16,
    parameter int CIC_ORDER  = 3,
    parameter int DEC_LOG2   = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         aclk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         in_sel,
    input  logic [MASH_BW-1:0]           in_mash_data,
    input  logic                         in_dsm_bit,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  drop_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int GW = calc_gw(MASH_BW, CIC_ORDER, DEC_LOG2);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] WARM_INIT = 3'(CIC_ORDER - 1);

    state_e                state_q, state_d;
    logic [2:0]            warm_q, warm_d;
    logic                  accept, wr_req, full, drop;
    logic [DEC_LOG2-1:0]   phase_q;
    logic                  dec_v_q, samp_v_q;
    logic signed [GW-1:0]  samp_q;
    logic signed [63:0]    mapped;
    logic signed [GW-1:0]  x_ext;
    logic signed [GW-1:0]  integ_q [CIC_ORDER];
    logic signed [GW-1:0]  integ_d [CIC_ORDER];
    logic signed [GW-1:0]  comb_q  [CIC_ORDER];
    logic signed [GW-1:0]  prev_q  [CIC_ORDER];
    logic signed [GW-1:0]  st_in   [CIC_ORDER];
    logic [CIC_ORDER-1:0]  cv_q, st_v;
    logic [WIDTH-1:0]      scaled;
    logic [15:0]           drop_q;

    assign accept = enable & in_valid;
    assign mapped = map_sample(in_sel, longint'($signed(in_mash_data)), in_dsm_bit);
    assign x_ext  = mapped[GW-1:0];

    // Integrators chain through their next values so the last stage already
    // holds the full N-fold sum including the sample accepted this cycle.
    always_comb begin
        integ_d[0] = integ_q[0] + x_ext;
        for (int i = 1; i < CIC_ORDER; i++) begin
            integ_d[i] = integ_q[i] + integ_d[i-1];
        end
    end

    always_comb begin
        st_in[0] = samp_q;
        st_v[0]  = samp_v_q;
        for (int s = 1; s < CIC_ORDER; s++) begin
            st_in[s] = comb_q[s-1];
            st_v[s]  = cv_q[s-1];
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            dec_v_q  <= 1'b0;
            samp_v_q <= 1'b0;
            samp_q   <= '0;
            cv_q     <= '0;
            for (int i = 0; i < CIC_ORDER; i++) begin
                integ_q[i] <= '0;
                comb_q[i]  <= '0;
                prev_q[i]  <= '0;
            end
        end else if (!enable) begin
            phase_q  <= '0;
            dec_v_q  <= 1'b0;
            samp_v_q <= 1'b0;
            samp_q   <= '0;
            cv_q     <= '0;
            for (int i = 0; i < CIC_ORDER; i++) begin
                integ_q[i] <= '0;
                comb_q[i]  <= '0;
                prev_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                phase_q <= phase_q + 1'b1;
                for (int i = 0; i < CIC_ORDER; i++) begin
                    integ_q[i] <= integ_d[i];
                end
            end
            dec_v_q  <= accept && (phase_q == '1);
            samp_v_q <= dec_v_q;
            if (dec_v_q) samp_q <= integ_q[CIC_ORDER-1];
            for (int s = 0; s < CIC_ORDER; s++) begin
                cv_q[s] <= st_v[s];
                if (st_v[s]) begin
                    comb_q[s] <= st_in[s] - prev_q[s];
                    prev_q[s] <= st_in[s];
                end
            end
        end
    end

    generate
        if (GW >= WIDTH) begin : g_trunc
            assign scaled = comb_q[CIC_ORDER-1][GW-1 -: WIDTH];
        end else begin : g_pad
            assign scaled = {comb_q[CIC_ORDER-1], {(WIDTH-GW){1'b0}}};
        end
    endgenerate

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            warm_q  <= WARM_INIT;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        wr_req  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            warm_d  = WARM_INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WARMUP;
                    warm_d  = WARM_INIT;
                end
                WARMUP: begin
                    if (cv_q[CIC_ORDER-1]) begin
                        if (warm_q == '0) state_d = RUN;
                        else              warm_d  = warm_q - 1'b1;
                    end
                end
                RUN:     wr_req  = cv_q[CIC_ORDER-1];
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef DSM_DEC_FIFO_EN
    logic flush;
    assign flush = ~enable;

    dsm_dec_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_en    (wr_req),
        .wr_data  (scaled),
        .full     (full),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_data),
        .level    (fifo_level)
    );
`else
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (!enable) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (wr_req && (!out_valid_q || out_ready)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= scaled;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign full       = out_valid_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fifo_level = {{(LW-1){1'b0}}, out_valid_q};
`endif

    // A full buffer still takes the write when the head leaves this cycle.
    assign drop = wr_req & full & ~(out_valid & out_ready);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
module tb_dsm_cic_decimator;

    localparam int MASH_BW = 3;
    localparam int WIDTH   = 16;
    localparam int N       = 3;
    localparam int DL      = 5;
    localparam int FD      = 4;
    localparam int R       = 1 << DL;
    localparam int GW      = MASH_BW + N * DL;
`ifdef DSM_DEC_FIFO_EN
    localparam int DEPTH = FD;
`else
    localparam int DEPTH = 1;
`endif

    logic                  aclk = 1'b0;
    logic                  rst_n, enable, in_sel, in_dsm_bit, in_valid, out_ready;
    logic [MASH_BW-1:0]    in_mash_data;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [15:0]           drop_count;
    logic [$clog2(FD):0]   fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    int xs[$];
    int got[$];
    int h[$];
    int exp_drops = 0;

    dsm_cic_decimator #(
        .MASH_BW(MASH_BW), .WIDTH(WIDTH), .CIC_ORDER(N), .DEC_LOG2(DL), .FIFO_DEPTH(FD)
    ) dut (
        .aclk(aclk), .rst_n(rst_n), .enable(enable), .in_sel(in_sel),
        .in_mash_data(in_mash_data), .in_dsm_bit(in_dsm_bit), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 aclk = ~aclk;

    // Inputs change 1 time unit after the rising edge, so at the falling edge
    // out_valid/out_ready show exactly what the next rising edge will see.
    always @(negedge aclk) begin
        if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Impulse response of ((1 - z^-R) / (1 - z^-1))^N: N-fold boxcar convolution.
    task automatic build_h();
        int cur[$];
        cur.push_back(1);
        for (int n = 0; n < N; n++) begin
            int nxt[$];
            for (int i = 0; i < cur.size() + R - 1; i++) nxt.push_back(0);
            for (int i = 0; i < cur.size(); i++)
                for (int k = 0; k < R; k++) nxt[i+k] += cur[i];
            cur = nxt;
        end
        h = cur;
    endtask

    // d-th decimated output (1-based) for the accepted samples in xs.
    function automatic int model_out(input int d);
        longint acc  = 0;
        longint m    = 64'sd1 <<< GW;
        int     base = d * R - 1;
        for (int j = 0; j < h.size(); j++)
            if (base - j >= 0) acc += longint'(h[j]) * longint'(xs[base-j]);
        acc = acc % m;
        if (acc < 0) acc += m;
        if (acc >= m / 2) acc -= m;
        return int'(acc >>> (GW - WIDTH));
    endfunction

    function automatic void build_exp(output int q[$]);
        q.delete();
        for (int d = N + 1; d <= xs.size() / R; d++) q.push_back(model_out(d));
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input bit sel, input int v);
        in_sel = sel;
        if (sel) begin
            in_dsm_bit   = v[0];
            in_mash_data = 3'($urandom);
            xs.push_back(v[0] ? 1 : -1);
        end else begin
            in_mash_data = 3'(v);
            in_dsm_bit   = 1'($urandom);
            xs.push_back(v);
        end
        in_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid     = 1'b0;
        in_mash_data = 3'($urandom);
        in_dsm_bit   = 1'($urandom);
        repeat (n) tick();
    endtask

    task automatic restart();
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        xs.delete();
        got.delete();
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; in_sel = 1'b0; in_dsm_bit = 1'b0;
        in_valid = 1'b0; in_mash_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        n_cmp++; if (fifo_level !== '0) begin n_bad++; $display("FAIL reset_fifo_level: got %0d expected 0", fifo_level); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency_dc();
        int exp_q[$];
        restart();
        repeat (4 * R) push(1'b0, 1);
        idle(4);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_early: out_valid %0b expected 0 at edge k+4", out_valid); end
        idle(1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_on_time: out_valid %0b expected 1 at edge k+5", out_valid); end
        repeat (4 * R) push(1'b0, 1);
        idle(12);
        build_exp(exp_q);
        n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++; $display("FAIL dc_plus1_count: got %0d expected %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL dc_plus1_model[%0d]: got %0d expected %0d", i, got[i], exp_q[i]); end
            n_cmp++; if (got[i] !== 8192) begin n_bad++; $display("FAIL dc_plus1_gain[%0d]: got %0d expected 8192", i, got[i]); end
        end
    endtask

    task automatic test_dsm();
        int exp_q[$];
        int want [3] = '{8192, -8192, 0};
        for (int p = 0; p < 3; p++) begin
            restart();
            for (int i = 0; i < 8 * R; i++) push(1'b1, (p == 0) ? 1 : (p == 1) ? 0 : ((i % 2 == 0) ? 1 : 0));
            idle(12);
            build_exp(exp_q);
            n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++; $display("FAIL dsm%0d_count: got %0d expected %0d", p, got.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got.size()) begin
                n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL dsm%0d_model[%0d]: got %0d expected %0d", p, i, got[i], exp_q[i]); end
                n_cmp++; if (got[i] !== want[p]) begin n_bad++; $display("FAIL dsm%0d_level[%0d]: got %0d expected %0d", p, i, got[i], want[p]); end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_q[$];
        int val  [2] = '{3, -4};
        int want [2] = '{24576, -32768};
        for (int p = 0; p < 2; p++) begin
            restart();
            repeat (10000) push(1'b0, val[p]);
            idle(12);
            build_exp(exp_q);
            n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++; $display("FAIL wrap%0d_count: got %0d expected %0d", p, got.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got.size()) begin
                n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap%0d_model[%0d]: got %0d expected %0d", p, i, got[i], exp_q[i]); end
                n_cmp++; if (got[i] !== want[p]) begin n_bad++; $display("FAIL wrap%0d_level[%0d]: got %0d expected %0d", p, i, got[i], want[p]); end
            end
        end
    endtask

    task automatic test_random();
        int exp_q[$];
        restart();
        while (xs.size() < 14 * R) begin
            if ($urandom_range(0, 9) < 3) idle(1);
            else if ($urandom_range(0, 3) == 0) push(1'b1, int'($urandom_range(0, 1)));
            else push(1'b0, int'($urandom_range(0, 7)) - 4);
        end
        idle(12);
        build_exp(exp_q);
        n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++; $display("FAIL random_count: got %0d expected %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_model[%0d]: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int exp_q[$];
        out_ready = 1'b0;
        restart();
        repeat (9 * R) push(1'b0, int'($urandom_range(0, 7)) - 4);
        idle(12);
        build_exp(exp_q);
        exp_drops += (9 - N) - DEPTH;
        n_cmp++; if (fifo_level !== 3'(DEPTH)) begin n_bad++; $display("FAIL bp_level: got %0d expected %0d", fifo_level, DEPTH); end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL bp_drops: got %0d expected %0d", drop_count, exp_drops); end
        n_cmp++; if (int'($signed(out_data)) !== exp_q[0]) begin n_bad++; $display("FAIL bp_head: got %0d expected %0d", $signed(out_data), exp_q[0]); end
        idle(5);
        n_cmp++; if (int'($signed(out_data)) !== exp_q[0] || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %0d valid %0b expected %0d valid 1", $signed(out_data), out_valid, exp_q[0]); end
        out_ready = 1'b1;
        idle(DEPTH + 3);
        n_cmp++; if (got.size() !== DEPTH) begin n_bad++; $display("FAIL bp_drain_count: got %0d expected %0d", got.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_drain[%0d]: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (fifo_level !== '0) begin n_bad++; $display("FAIL bp_empty: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_enable_flush();
        int exp_q[$];
        int held;
        out_ready = 1'b0;
        restart();
        repeat (5 * R + 17) push(1'b0, int'($urandom_range(0, 7)) - 4);
        held = (DEPTH < 2) ? DEPTH : 2;
        exp_drops += 2 - held;
        n_cmp++; if (fifo_level !== 3'(held)) begin n_bad++; $display("FAIL flush_pre_level: got %0d expected %0d", fifo_level, held); end
        enable   = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || fifo_level !== '0) begin n_bad++; $display("FAIL flush_empty: valid %0b level %0d expected 0 0", out_valid, fifo_level); end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL flush_drops: got %0d expected %0d", drop_count, exp_drops); end
        xs.delete();
        got.delete();
        out_ready = 1'b1;
        enable    = 1'b1;
        repeat (8 * R) push(1'b0, int'($urandom_range(0, 7)) - 4);
        idle(12);
        build_exp(exp_q);
        n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++; $display("FAIL flush_rerun_count: got %0d expected %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL flush_rerun[%0d]: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL flush_drops_kept: got %0d expected %0d", drop_count, exp_drops); end
    endtask

    task automatic test_async_reset();
        int held;
        out_ready = 1'b0;
        restart();
        repeat (5 * R + 10) push(1'b0, int'($urandom_range(0, 7)) - 4);
        held = (DEPTH < 2) ? DEPTH : 2;
        exp_drops += 2 - held;
        n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL arst_pre_drops: got %0d expected %0d", drop_count, exp_drops); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_bad++; $display("FAIL arst_out: valid %0b data %0d expected 0 0", out_valid, out_data); end
        n_cmp++; if (fifo_level !== '0 || drop_count !== 16'd0) begin n_bad++; $display("FAIL arst_status: level %0d drops %0d expected 0 0", fifo_level, drop_count); end
        #2 rst_n = 1'b1;
        exp_drops = 0;
        idle(8);
        n_cmp++; if (out_valid !== 1'b0 || drop_count !== 16'd0) begin n_bad++; $display("FAIL arst_after: valid %0b drops %0d expected 0 0", out_valid, drop_count); end
    endtask

    initial begin
        build_h();
        test_reset();
        test_latency_dc();
        test_dsm();
        test_wrap();
        test_random();
        test_backpressure();
        test_enable_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsm_cic_decimator.md
# dsm_cic_decimator

Receive-side decoder for the MASH/DSM modulator output: rebuilds multibit baseband samples from either the signed MASH_BW-bit MASH stream or the 1-bit DSM stream. It runs a CIC (sinc^N) decimator with a small output FIFO and a valid/ready handshake. It sits in the aclk domain beside the modulator core as an on-chip loopback demodulator for BIST and self-check of the transmit path.

## Interface
- MASH_BW, 3, width of signed MASH input sample
- WIDTH, 16, output sample width (matches transmit sample width)
- CIC_ORDER, 3, integrator/comb stage count N, legal 1..4
- DEC_LOG2, 5, log2 of decimation ratio R (R = 32), legal 1..8
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)
- aclk  in  1  block clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run when high; low = synchronous flush to IDLE
- in_sel  in  1  0: use in_mash_data; 1: use in_dsm_bit mapped 1->+1, 0->-1
- in_mash_data  in  MASH_BW  signed MASH sample
- in_dsm_bit  in  1  1-bit DSM sample
- in_valid  in  1  input sample qualifier; no backpressure, always accepted when enable high
- out_data  out  WIDTH  signed decimated sample
- out_valid  out  1  out_data holds a sample
- out_ready  in  1  consumer accepts when out_valid & out_ready
- drop_count  out  16  decimated samples lost to a full FIFO, saturating
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Internal width GW = MASH_BW + CIC_ORDER*DEC_LOG2 (18 at defaults); all integrators/combs GW-bit two's complement, wrapping modulo 2^GW (wrap is required, never saturate).
- Input sample x sign-extended to GW; integrators update on each accepted in_valid only.
- Phase counter 0..R-1 increments per accepted sample; on accept at phase R-1, last integrator value is latched into comb pipeline and phase wraps to 0.
- Combs: one registered stage per order, y = x - x_prev, x_prev updated on decimated sample only.
- Scaling: GW >= WIDTH -> out = comb[GW-1 -: WIDTH] (truncation toward -inf); GW < WIDTH -> comb left-aligned, LSBs zero. DC gain of full-scale +1 input = R^N >> (GW-WIDTH).
- States: IDLE (enable low; integrators, combs, phase, FIFO cleared), WARMUP (first CIC_ORDER decimated samples discarded, not counted as drops), RUN (decimated samples written to FIFO). IDLE->WARMUP when enable high; WARMUP->RUN after CIC_ORDER-th discard; any state->IDLE the cycle after enable low.
- FIFO full at write: sample dropped, drop_count += 1 (sticks at 0xFFFF). Full with simultaneous read: write accepted.
- drop_count cleared only by rst_n; survives enable toggles.

## Timing
- Reset: out_valid 0, out_data 0, drop_count 0, fifo_level 0, state IDLE, phase 0.
- Latency: accept of R-th input at edge k -> out_valid high after edge k+CIC_ORDER+2 with FIFO empty.
- Sustains in_valid every cycle; decimated outputs never collide.
- out_data stable while out_valid & !out_ready.
- enable low mid-sample: partial period discarded, FIFO flushed, out_valid 0 next cycle.
- rst_n assert mid-operation: immediate async clear, no partial outputs.

## Configuration
- DSM_DEC_FIFO_EN defined: output buffer is FIFO_DEPTH-entry FIFO as above.
- Undefined: single output register (effective depth 1); fifo_level 0/1; drop rules unchanged; FIFO_DEPTH ignored.

## Structure
- Package dsm_dec_pkg: state enum (IDLE, WARMUP, RUN), function computing GW, sample mapping function for in_sel.
- Sub-module dsm_dec_fifo: synchronous FIFO with valid/ready read port, full flag and level; instantiated only under DSM_DEC_FIFO_EN.

## Test plan
- in_sel=0, in_mash_data=+1 every cycle, defaults -> after 3 discarded outputs every out_data = 8192; fourth decimation yields first out_valid at CIC_ORDER+2 cycles.
- in_sel=1, in_dsm_bit all 1 -> 8192; all 0 -> -8192; alternating 1/0 -> 0 after warmup.
- in_mash_data=+3 for 10000 samples (integrators wrap) -> steady 24576; -4 -> -32768.
- out_ready=0, 9 decimation periods -> 3 discards, 4 stored, fifo_level 4, drop_count 2; then out_ready=1 drains 4 samples in order.
- enable dropped at phase 17 then raised -> FIFO empty next cycle, WARMUP restarts, drop_count unchanged.
- rst_n pulsed mid-period during backpressure -> all outputs to reset values asynchronously, drop_count 0.
